pwm_modulator: RTL and testbench
================================

# pwm_modulator

Synchronous PWM generator that consumes the divided square wave from the frequency divider as its step rate. Each rising edge of that wave advances an N-bit period counter, and the output is compared against a double-buffered duty value. Duty updates arrive over a valid/ready handshake and take effect only at period boundaries, so the output never glitches. The block sits between the clock-divider chain and the motor/LED driver pins.

## Interface
- `WIDTH`, default 8: duty and counter resolution; period = 2^WIDTH steps.
- `SYNC_STAGES`, default 2: synchronizer depth on `tick_in`; minimum 2.
- `clk`  in  1: system clock; all state on rising edge.
- `rst`  in  1: reset, asynchronous assert, active-low (0 = reset).
- `en`  in  1: run enable; 0 forces idle.
- `tick_in`  in  1: divided square wave from the divider; treated as asynchronous.
- `duty_in`  in  WIDTH: requested duty, high count per period.
- `duty_valid`  in  1: `duty_in` is valid.
- `duty_ready`  out  1: shadow register empty; transfer occurs on `duty_valid && duty_ready`.
- `pwm_out`  out  1: registered PWM output.
- `period_start`  out  1: one-cycle pulse on each step where the counter is 0.

## Operation
- `tick_in` passes through `SYNC_STAGES` flops and one edge register. `step` = synced & ~prev, giving one `clk` pulse per rising edge.
- FSM states: ST_IDLE and ST_RUN.
  - ST_IDLE: `cnt`=0, `pwm_out`=0. Go to ST_RUN on `step && en`; that step counts as a period boundary.
  - ST_RUN: on each `step`, `cnt` <= `cnt`+1 modulo 2^WIDTH. `en`=0 returns to ST_IDLE next cycle, clears `cnt`, and drives `pwm_out` to 0.
- Duty path: `shadow` (WIDTH bits) plus `pending` flag, and an `active` register.
  - Handshake accept loads `shadow` and sets `pending`. `duty_ready` = ~`pending`.
  - Period boundary is a step where `cnt` becomes or stays 0, including the IDLE→RUN step. At a boundary with `pending`=1, `active` <= `shadow` and `pending` clears.
- Output: on each step in ST_RUN, `pwm_out` <= (new `cnt` < `active`). Between steps `pwm_out` holds.
  - `active`=0 gives a constant low output.
  - `active`=2^WIDTH−1 gives high for 2^WIDTH−1 steps and low for 1 step.
- Boundary conditions:
  - Accept and boundary in the same cycle: the value lands in `shadow` and applies at the next boundary. There is no bypass.
  - `duty_valid` held while `pending`: the request stalls and `duty_in` must stay stable.
  - `en` dropped: `pending`, `shadow` and `active` are retained and reused on re-entry.
  - Reset mid-operation: all state returns to reset values immediately and pending duty is discarded.

## Timing
- Reset values: `pwm_out`=0, `period_start`=0, `duty_ready`=1, `cnt`=0, `active`=0, `pending`=0, FSM=ST_IDLE.
- `tick_in` rising edge to `step`: `SYNC_STAGES`+1 cycles (3 by default).
- `step` to `pwm_out` and `period_start` update: 1 cycle.
- `duty_ready` falls the cycle after accept. It rises the cycle after the boundary that consumes `shadow`.
- `tick_in` high and low phases must each be at least `SYNC_STAGES`+1 `clk` cycles. Faster input is out of contract.

## Configuration
- `PWM_COMPLEMENT_EN` defined:
  - Adds output `pwm_n` (1 bit), registered, equal to ~`pwm_out` while in ST_RUN.
  - `pwm_n` is forced to 0 in ST_IDLE and in reset, so both outputs are never high together.
- Not defined: the `pwm_n` port and its logic are absent.

## Structure
- Shared package `pwm_pkg`: FSM state typedef (ST_IDLE, ST_RUN), default `WIDTH`, default `SYNC_STAGES`.
- One sub-module: `tick_sync`. It contains the `SYNC_STAGES` synchronizer and rising-edge detector, outputs the `step` pulse, and is reusable by other consumers of the divider.

## Test plan
- Reset release with `en`=1, no duty written, `tick_in` toggling every 8 cycles → `pwm_out` stays 0; `period_start` pulses every 256 steps; `duty_ready`=1.
- Write duty 64 before the first step, `WIDTH`=8 → from the first boundary, `pwm_out` is high for 64 steps and low for 192 steps, repeating.
- Write 200 mid-period while `active`=64 → current period completes with 64 steps high; next period has 200 steps high. `duty_ready` is low until that boundary; a second write during that time stalls.
- Accept duty 10 in the same cycle as a boundary → that period uses the old duty; 10 applies one period later.
- Drop `en` mid-period at `cnt`=100 → `pwm_out`=0 and `cnt`=0 next cycle. Re-enable → restarts at a boundary with the retained duty.
- Assert `rst`=0 asynchronously between clock edges while `pwm_out`=1 → all outputs reach reset values before the next clock edge; a previously pending duty is not applied after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM modulator: FSM state type and default parameters.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH_DEF = 8;
  localparam int unsigned PWM_SYNC_DEF  = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/pwm_modulator_tick_sync.sv
// Synchronizes an asynchronous divided clock and emits a one-cycle step pulse on each rising edge.
module tick_sync
  import pwm_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = PWM_SYNC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  output logic step_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign step_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pwm_modulator.sv
// PWM generator stepped by a synchronized divider tick, with a double-buffered duty register.
// Optional complementary output pwm_n is built when PWM_COMPLEMENT_EN is defined.
module pwm_modulator
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH       = PWM_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = PWM_SYNC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick_in,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  output logic             pwm_out,
  output logic             period_start
`ifdef PWM_COMPLEMENT_EN
  ,
  output logic             pwm_n
`endif
);

  pwm_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             ps_q, ps_d;
  logic             step, advance, boundary;

  tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
    .clk    (clk),
    .rst    (rst),
    .tick_i (tick_in),
    .step_o (step)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    pwm_d     = pwm_q;
    ps_d      = 1'b0;
    advance   = step & en;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      pwm_d   = 1'b0;
    end else if (advance) begin
      state_d = ST_RUN;
      cnt_d   = (state_q == ST_RUN) ? cnt_q + 1'b1 : '0;
    end

    // The IDLE->RUN step also lands on zero, so it is a boundary too.
    boundary = advance && (cnt_d == '0);
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    // Accept only writes the shadow; a same-cycle boundary used the old pending state.
    if (duty_valid && !pending_q) begin
      shadow_d  = duty_in;
      pending_d = 1'b1;
    end

    if (advance) begin
      pwm_d = (cnt_d < active_d);
      ps_d  = boundary;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      pwm_q     <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      ps_q      <= ps_d;
    end
  end

  assign duty_ready   = ~pending_q;
  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

`ifdef PWM_COMPLEMENT_EN
  logic pwm_n_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pwm_n_q <= 1'b0;
    end else begin
      pwm_n_q <= (state_d == ST_RUN) & ~pwm_d;
    end
  end

  assign pwm_n = pwm_n_q;
`endif

endmodule

// File: tb/tb_pwm_modulator.sv
// Scoreboard bench for pwm_modulator: per-step expectations are queued by the stimulus and checked by a monitor.
module tb_pwm_modulator;
  import pwm_pkg::*;

  localparam int W   = PWM_WIDTH_DEF;
  localparam int PER = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         tick_in = 1'b0;
  logic [W-1:0] duty_in = '0;
  logic         duty_valid = 1'b0;
  logic         duty_ready, pwm_out, period_start;
`ifdef PWM_COMPLEMENT_EN
  logic         pwm_n;
`endif

  int errors = 0;
  int checks = 0;
  int ps_seen = 0;

  typedef struct packed {
    logic pwm;
    logic ps;
    logic rdy;
    logic run;
  } exp_t;
  exp_t sbq[$];

  bit m_run, m_pending, m_pwm, m_ps;
  int m_cnt, m_active, m_shadow;

  pwm_modulator #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .tick_in      (tick_in),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .period_start (period_start)
`ifdef PWM_COMPLEMENT_EN
    ,
    .pwm_n        (pwm_n)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_run = 0; m_pending = 0; m_pwm = 0; m_ps = 0;
    m_cnt = 0; m_active = 0; m_shadow = 0;
  endfunction

  function automatic void m_step();
    m_ps = 0;
    if (!en) return;
    if (!m_run) begin
      m_run = 1;
      m_cnt = 0;
    end else begin
      m_cnt = (m_cnt + 1) % PER;
    end
    if (m_cnt == 0 && m_pending) begin
      m_active  = m_shadow;
      m_pending = 0;
    end
    m_pwm = (m_cnt < m_active);
    m_ps  = (m_cnt == 0);
  endfunction

  // One tick period: 4 cycles high, 4 low. With acc set, a duty write is
  // presented exactly on the clock edge that consumes this step.
  task automatic win(input bit acc, input logic [W-1:0] v);
    exp_t e;
    @(negedge clk);
    tick_in = 1'b1;
    m_step();
    if (acc) begin
      m_shadow  = v;
      m_pending = 1;
    end
    e.pwm = m_pwm; e.ps = m_ps; e.rdy = !m_pending; e.run = m_run;
    sbq.push_back(e);
    @(negedge clk);
    @(negedge clk);
    if (acc) begin
      duty_in    = v;
      duty_valid = 1'b1;
    end
    @(negedge clk);
    duty_valid = 1'b0;
    @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) win(1'b0, '0);
  endtask

  task automatic run_to(input int c);
    for (int i = 0; i < 300 && m_cnt != c; i++) win(1'b0, '0);
  endtask

  task automatic write_duty(input logic [W-1:0] v);
    @(negedge clk);
    chk("ready_before_write", duty_ready, !m_pending);
    duty_in    = v;
    duty_valid = 1'b1;
    @(negedge clk);
    duty_valid = 1'b0;
    if (!m_pending) begin
      m_shadow  = v;
      m_pending = 1;
    end
    chk("ready_after_accept", duty_ready, !m_pending);
  endtask

  task automatic stall_write(input logic [W-1:0] v);
    @(negedge clk);
    duty_in    = v;
    duty_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ready_stall", duty_ready, !m_pending);
    end
    duty_valid = 1'b0;
  endtask

  always @(negedge clk) if (period_start === 1'b1) ps_seen++;

  // Monitor: each step's outputs have settled well before 6 cycles after the tick edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge tick_in);
      repeat (6) @(negedge clk);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got no expectation, required one at %0t", $time);
      end else begin
        e = sbq.pop_front();
        chk("pwm_out", pwm_out, e.pwm);
        chk("period_start", ps_seen, e.ps);
        chk("duty_ready", duty_ready, e.rdy);
`ifdef PWM_COMPLEMENT_EN
        chk("pwm_n", pwm_n, e.run ? !e.pwm : 1'b0);
`endif
      end
      ps_seen = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pwm_out", pwm_out, 1'b0);
    chk("rst_period_start", period_start, 1'b0);
    chk("rst_duty_ready", duty_ready, 1'b1);
    rst = 1'b1;
    en  = 1'b1;

    // No duty written: output stays low, period_start every 256 steps.
    run(257);

    // Duty 64 applies at the next boundary, then a full period is checked.
    write_duty(8'd64);
    run(256);
    run(256);

    // Mid-period update to 200 with a stalled second write.
    run_to(50);
    write_duty(8'd200);
    stall_write(8'd77);
    run_to(0);
    run_to(100);

    // Drop enable at cnt=100 while high.
    @(negedge clk);
    en = 1'b0;
    m_run = 0; m_cnt = 0; m_pwm = 0;
    @(negedge clk);
    chk("en_drop_pwm_out", pwm_out, 1'b0);
`ifdef PWM_COMPLEMENT_EN
    chk("en_drop_pwm_n", pwm_n, 1'b0);
`endif
    run(2);
    en = 1'b1;
    run(3);

    // Accept coinciding with a boundary takes effect one period later.
    run_to(PER - 1);
    win(1'b1, 8'd10);
    run(PER - 1);
    run(1);
    run(12);

    // Asynchronous reset while high with a pending duty.
    run_to(5);
    write_duty(8'd99);
    @(negedge clk);
    chk("pre_rst_pwm_out", pwm_out, m_pwm);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_pwm_out", pwm_out, 1'b0);
    chk("async_rst_period_start", period_start, 1'b0);
    chk("async_rst_duty_ready", duty_ready, 1'b1);
`ifdef PWM_COMPLEMENT_EN
    chk("async_rst_pwm_n", pwm_n, 1'b0);
`endif
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run(3);

    repeat (10) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
